// File: rtl/dcache_evict_reader.sv
// dcache_evict_reader
// -------------------
// Read-side master for one dcache way data RAM. An accepted eviction reads
// the 64B line as two 32B half-line reads (low half, then high half),
// buffers both halves and streams them to the writeback interface as two
// valid/ready beats. Any half-line read flagged by the RAM read/write
// conflict output is re-issued in the following cycle.
//
// Optional build macro: DCACHE_EVICT_EARLY_SEND_EN
//   Defined   : the low beat is already offered in CAP_HI, while the high
//               half is being captured, saving one cycle per eviction.
//   Undefined : beats are offered only in SEND_LO / SEND_HI.
//
// Ports
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   evict_req_i       eviction request
//   evict_addr_i      line address, bits [WORD_SEL+1:0] ignored
//   evict_ack_o       request accepted this cycle (IDLE only)
//   busy_o            eviction in progress
//   rd_en_o           RAM read enable (registered)
//   rd_addr_o         RAM read address (registered)
//   rd_wr_conflict_i  RAM conflict flag for the read issued this cycle
//   rd_half_data_i    RAM read data, valid one cycle after rd_en_o
//   wb_valid_o        writeback beat valid
//   wb_ready_i        writeback sink ready
//   wb_addr_o         beat address (line base, half bit = beat index)
//   wb_data_o         beat data
//   wb_last_o         high on the high-half beat
module dcache_evict_reader #(
   parameter int AWT           = 32,
   parameter int WORD_SEL      = 4,
   parameter int ENTRY_SEL     = 7,
   parameter int HALF_LINE_DWT = 256
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     evict_req_i,
   input  logic [AWT-1:0]           evict_addr_i,
   output logic                     evict_ack_o,
   output logic                     busy_o,
   output logic                     rd_en_o,
   output logic [AWT-1:0]           rd_addr_o,
   input  logic                     rd_wr_conflict_i,
   input  logic [HALF_LINE_DWT-1:0] rd_half_data_i,
   output logic                     wb_valid_o,
   input  logic                     wb_ready_i,
   output logic [AWT-1:0]           wb_addr_o,
   output logic [HALF_LINE_DWT-1:0] wb_data_o,
   output logic                     wb_last_o
);

   localparam int HALF_BIT = WORD_SEL + 1;

   // The line index field must fit inside the address.
   if (ENTRY_SEL + WORD_SEL + 2 > AWT) begin : g_bad_cfg
      $error("dcache_evict_reader: line index does not fit in AWT");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_CAP_HI,
      S_SEND_LO,
      S_SEND_HI
   } state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [AWT-1:0]           r_base;
   logic [AWT-1:0]           w_base_next;
   logic                     r_rd_en;
   logic [AWT-1:0]           r_rd_addr;
   logic [AWT-1:0]           w_rd_addr_next;
   logic                     w_rd_next;
   // Set when the read issued last cycle was not conflicted, i.e. the data
   // on rd_half_data_i this cycle is a good result for that half.
   logic                     r_cap_lo;
   logic                     r_cap_hi;
   logic [HALF_LINE_DWT-1:0] r_buf0;
   logic [HALF_LINE_DWT-1:0] r_buf1;
   logic                     r_buf0_vld;
   logic                     r_buf1_vld;
   logic                     w_ack;
   logic                     w_wb_valid;
   logic                     w_wb_half;
   logic [AWT-1:0]           w_wb_addr;
   logic                     w_unused;

   assign w_unused = ^evict_addr_i[WORD_SEL+1:0];

   always_comb begin
      w_state_next = r_state;
      w_ack        = 1'b0;
      w_wb_valid   = 1'b0;
      w_wb_half    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (evict_req_i && !rst_i) begin
               w_ack        = 1'b1;
               w_state_next = S_RD_LO;
            end
         end
         S_RD_LO: begin
            if (!rd_wr_conflict_i) w_state_next = S_RD_HI;
         end
         S_RD_HI: begin
            if (!rd_wr_conflict_i) w_state_next = S_CAP_HI;
         end
         S_CAP_HI: begin
`ifdef DCACHE_EVICT_EARLY_SEND_EN
            // buf0 is always captured by now; the flag keeps the low beat
            // from ever being offered ahead of its data.
            w_wb_valid = r_buf0_vld;
            if (r_buf0_vld && wb_ready_i) w_state_next = S_SEND_HI;
            else                          w_state_next = S_SEND_LO;
`else
            w_state_next = S_SEND_LO;
`endif
         end
         S_SEND_LO: begin
            w_wb_valid = 1'b1;
            if (wb_ready_i) w_state_next = S_SEND_HI;
         end
         S_SEND_HI: begin
            w_wb_valid = 1'b1;
            w_wb_half  = 1'b1;
            if (wb_ready_i) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase

      w_base_next = r_base;
      if (w_ack) w_base_next = {evict_addr_i[AWT-1:WORD_SEL+2], {(WORD_SEL+2){1'b0}}};

      // Read port is registered from the next state so it lines up with
      // RD_LO / RD_HI without a combinational path to the RAM.
      w_rd_next      = (w_state_next == S_RD_LO) || (w_state_next == S_RD_HI);
      w_rd_addr_next = '0;
      if (w_rd_next) begin
         w_rd_addr_next           = w_base_next;
         w_rd_addr_next[HALF_BIT] = (w_state_next == S_RD_HI);
      end

      w_wb_addr           = r_base;
      w_wb_addr[HALF_BIT] = w_wb_half;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_rd_en    <= 1'b0;
         r_rd_addr  <= '0;
         r_cap_lo   <= 1'b0;
         r_cap_hi   <= 1'b0;
         r_buf0     <= '0;
         r_buf1     <= '0;
         r_buf0_vld <= 1'b0;
         r_buf1_vld <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_base    <= w_base_next;
         r_rd_en   <= w_rd_next;
         r_rd_addr <= w_rd_addr_next;
         r_cap_lo  <= (r_state == S_RD_LO) && !rd_wr_conflict_i;
         r_cap_hi  <= (r_state == S_RD_HI) && !rd_wr_conflict_i;
         // Each good read is captured exactly once: the cap flags last one
         // cycle and a conflicted retry clears them.
         if (r_state == S_RD_HI && r_cap_lo) begin
            r_buf0     <= rd_half_data_i;
            r_buf0_vld <= 1'b1;
         end
         if (r_state == S_CAP_HI && r_cap_hi) begin
            r_buf1     <= rd_half_data_i;
            r_buf1_vld <= 1'b1;
         end
         if (r_state == S_SEND_HI && wb_ready_i) begin
            r_buf0_vld <= 1'b0;
            r_buf1_vld <= 1'b0;
         end
      end
   end

   assign evict_ack_o = w_ack;
   assign busy_o      = (r_state != S_IDLE);
   assign rd_en_o     = r_rd_en;
   assign rd_addr_o   = r_rd_addr;
   assign wb_valid_o  = w_wb_valid;
   assign wb_last_o   = w_wb_valid & w_wb_half;
   assign wb_addr_o   = w_wb_valid ? w_wb_addr : '0;
   assign wb_data_o   = !w_wb_valid ? '0 : (w_wb_half ? r_buf1 : r_buf0);

endmodule

// File: tb/tb_dcache_evict_reader.sv
// Table-driven bench for dcache_evict_reader. Each table row is one clock
// cycle: inputs to drive and the outputs expected in that cycle. A small
// RAM model returns a distinct pattern per read so retried and captured
// data can be told apart.
module tb_dcache_evict_reader;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         evict_req_i;
   logic [31:0]  evict_addr_i;
   logic         evict_ack_o;
   logic         busy_o;
   logic         rd_en_o;
   logic [31:0]  rd_addr_o;
   logic         rd_wr_conflict_i;
   logic [255:0] rd_half_data_i;
   logic         wb_valid_o;
   logic         wb_ready_i;
   logic [31:0]  wb_addr_o;
   logic [255:0] wb_data_o;
   logic         wb_last_o;

   dcache_evict_reader dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .evict_req_i      (evict_req_i),
      .evict_addr_i     (evict_addr_i),
      .evict_ack_o      (evict_ack_o),
      .busy_o           (busy_o),
      .rd_en_o          (rd_en_o),
      .rd_addr_o        (rd_addr_o),
      .rd_wr_conflict_i (rd_wr_conflict_i),
      .rd_half_data_i   (rd_half_data_i),
      .wb_valid_o       (wb_valid_o),
      .wb_ready_i       (wb_ready_i),
      .wb_addr_o        (wb_addr_o),
      .wb_data_o        (wb_data_o),
      .wb_last_o        (wb_last_o)
   );

   always #5 clk_i = ~clk_i;

   // Read pattern: 8 copies of {AA|BB by half, 00, 55, read count}.
   function automatic logic [255:0] mk(input logic hi, input logic [7:0] cnt);
      logic [31:0] w;
      w = {(hi ? 8'hBB : 8'hAA), 8'h00, 8'h55, cnt};
      return {8{w}};
   endfunction

   logic [7:0] rd_cnt;
   always @(posedge clk_i) begin
      if (rst_i) begin
         rd_cnt         <= 8'd0;
         rd_half_data_i <= '0;
      end else if (rd_en_o) begin
         rd_half_data_i <= mk(rd_addr_o[5], rd_cnt);
         rd_cnt         <= rd_cnt + 8'd1;
      end
   end

   typedef struct {
      logic         rst, req;
      logic [31:0]  addr;
      logic         conf, rdy;
      logic         ack, busy, rden;
      logic [31:0]  rda;
      logic         wbv;
      logic [31:0]  wba;
      logic         last;
      logic [255:0] data;
      logic         z;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   localparam logic [31:0] A  = 32'h0000_1A40;
   localparam logic [31:0] AH = 32'h0000_1A60;
   localparam logic [31:0] B  = 32'h0000_2FC0;
   localparam logic [31:0] BH = 32'h0000_2FE0;
   localparam logic [255:0] D = '0;

   function automatic void row(input logic rst, input logic req, input logic [31:0] addr,
                               input logic conf, input logic rdy, input logic ack,
                               input logic busy, input logic rden, input logic [31:0] rda,
                               input logic wbv, input logic [31:0] wba, input logic last,
                               input logic [255:0] data, input logic z);
      vec_t v;
      v.rst = rst; v.req = req; v.addr = addr; v.conf = conf; v.rdy = rdy;
      v.ack = ack; v.busy = busy; v.rden = rden; v.rda = rda; v.wbv = wbv;
      v.wba = wba; v.last = last; v.data = data; v.z = z;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   initial begin
      int k;
      int waited;
      rst_i = 1'b1; evict_req_i = 1'b0; evict_addr_i = '0;
      rd_wr_conflict_i = 1'b0; wb_ready_i = 1'b1;
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      chk("rst_ack",   256'(evict_ack_o), 256'(1'b0));
      chk("rst_busy",  256'(busy_o),      256'(1'b0));
      chk("rst_rden",  256'(rd_en_o),     256'(1'b0));
      chk("rst_rda",   256'(rd_addr_o),   256'(32'h0));
      chk("rst_wbv",   256'(wb_valid_o),  256'(1'b0));
      chk("rst_wba",   256'(wb_addr_o),   256'(32'h0));
      chk("rst_last",  256'(wb_last_o),   256'(1'b0));
      chk("rst_wbd",   wb_data_o,         D);
      @(posedge clk_i); #1;

`ifdef DCACHE_EVICT_EARLY_SEND_EN
      // No stalls: beats in cycles 3 and 4, IDLE in 5.
      row(0,1,A ,0,1, 1,0,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,A , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,AH, 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,A ,0,mk(0,0),0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,AH,1,mk(1,1),0);
      row(0,0,0 ,0,1, 0,0,0,0 , 0,0 ,0,D,0);
      // Sink not ready in CAP_HI: low beat held into SEND_LO.
      row(0,1,A ,0,1, 1,0,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,A , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,AH, 0,0 ,0,D,0);
      row(0,0,0 ,0,0, 0,1,0,0 , 1,A ,0,mk(0,2),0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,A ,0,mk(0,2),0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,AH,1,mk(1,3),0);
      row(0,0,0 ,0,1, 0,0,0,0 , 0,0 ,0,D,0);
      k = 4;
`else
      // Clean eviction, low address bits ignored.
      row(0,1,32'h1A55,0,1, 1,0,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,A , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,AH, 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,A ,0,mk(0,0),0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,AH,1,mk(1,1),0);
      row(0,0,0 ,0,1, 0,0,0,0 , 0,0 ,0,D,0);
      // Conflict on first RD_LO: low half re-read, second read used.
      row(0,1,A ,0,1, 1,0,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,1,1, 0,1,1,A , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,A , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,AH, 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,A ,0,mk(0,3),0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,AH,1,mk(1,4),0);
      row(0,0,0 ,0,1, 0,0,0,0 , 0,0 ,0,D,0);
      // Conflict on first RD_HI: buf0 kept, high half re-read.
      row(0,1,A ,0,1, 1,0,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,A , 0,0 ,0,D,0);
      row(0,0,0 ,1,1, 0,1,1,AH, 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,AH, 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,A ,0,mk(0,5),0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,AH,1,mk(1,7),0);
      row(0,0,0 ,0,1, 0,0,0,0 , 0,0 ,0,D,0);
      // Sink stalls in SEND_LO and SEND_HI; request held high, no ack.
      row(0,1,B ,0,1, 1,0,0,0 , 0,0 ,0,D,0);
      row(0,1,B ,0,1, 0,1,1,B , 0,0 ,0,D,0);
      row(0,1,B ,0,1, 0,1,1,BH, 0,0 ,0,D,0);
      row(0,1,B ,0,1, 0,1,0,0 , 0,0 ,0,D,0);
      row(0,1,B ,0,0, 0,1,0,0 , 1,B ,0,mk(0,8),0);
      row(0,1,B ,0,0, 0,1,0,0 , 1,B ,0,mk(0,8),0);
      row(0,1,B ,0,0, 0,1,0,0 , 1,B ,0,mk(0,8),0);
      row(0,1,B ,0,1, 0,1,0,0 , 1,B ,0,mk(0,8),0);
      row(0,1,B ,0,0, 0,1,0,0 , 1,BH,1,mk(1,9),0);
      row(0,1,B ,0,1, 0,1,0,0 , 1,BH,1,mk(1,9),0);
      // Back-to-back request acked in IDLE, then reset pulsed in RD_HI.
      row(0,1,A ,0,1, 1,0,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,A , 0,0 ,0,D,0);
      row(1,0,0 ,0,1, 0,1,1,AH, 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,0,0,0 , 0,0 ,0,D,1);
      row(0,1,A ,0,1, 1,0,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,A , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,1,AH, 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 0,0 ,0,D,0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,A ,0,mk(0,0),0);
      row(0,0,0 ,0,1, 0,1,0,0 , 1,AH,1,mk(1,1),0);
      row(0,0,0 ,0,1, 0,0,0,0 , 0,0 ,0,D,0);
      k = 2;
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         rst_i = v.rst; evict_req_i = v.req; evict_addr_i = v.addr;
         rd_wr_conflict_i = v.conf; wb_ready_i = v.rdy;
         #1;
         chk($sformatf("r%0d_ack", i),  256'(evict_ack_o), 256'(v.ack));
         chk($sformatf("r%0d_busy", i), 256'(busy_o),      256'(v.busy));
         chk($sformatf("r%0d_rden", i), 256'(rd_en_o),     256'(v.rden));
         chk($sformatf("r%0d_wbv", i),  256'(wb_valid_o),  256'(v.wbv));
         if (v.rden || v.z)
            chk($sformatf("r%0d_rda", i), 256'(rd_addr_o), 256'(v.rda));
         if (v.wbv || v.z) begin
            chk($sformatf("r%0d_wba", i),  256'(wb_addr_o), 256'(v.wba));
            chk($sformatf("r%0d_wbd", i),  wb_data_o,       v.data);
            chk($sformatf("r%0d_last", i), 256'(wb_last_o), 256'(v.last));
         end
         $display("vec %0d ack=%0b busy=%0b rden=%0b rda=%h wbv=%0b wba=%h last=%0b",
                  i, evict_ack_o, busy_o, rd_en_o, rd_addr_o, wb_valid_o, wb_addr_o, wb_last_o);
         @(posedge clk_i); #1;
      end

      // Five back-to-back conflicts on RD_LO: the read just repeats.
      rst_i = 1'b0; evict_req_i = 1'b1; evict_addr_i = A;
      rd_wr_conflict_i = 1'b0; wb_ready_i = 1'b1;
      #1;
      chk("storm_ack", 256'(evict_ack_o), 256'(1'b1));
      @(posedge clk_i); #1;
      evict_req_i = 1'b0; rd_wr_conflict_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("storm%0d_rden", c), 256'(rd_en_o),   256'(1'b1));
         chk($sformatf("storm%0d_rda", c),  256'(rd_addr_o), 256'(A));
         @(posedge clk_i); #1;
      end
      rd_wr_conflict_i = 1'b0;
      #1;
      waited = 0;
      while (!wb_valid_o && waited < 10) begin
         @(posedge clk_i); #2;
         waited++;
      end
      chk("storm_timeout", 256'(waited < 10), 256'(1'b1));
      chk("storm_b0_addr", 256'(wb_addr_o), 256'(A));
      chk("storm_b0_data", wb_data_o, mk(1'b0, 8'(k + 5)));
      chk("storm_b0_last", 256'(wb_last_o), 256'(1'b0));
      @(posedge clk_i); #2;
      chk("storm_b1_addr", 256'(wb_addr_o), 256'(AH));
      chk("storm_b1_data", wb_data_o, mk(1'b1, 8'(k + 6)));
      chk("storm_b1_last", 256'(wb_last_o), 256'(1'b1));
      @(posedge clk_i); #2;
      chk("storm_idle", 256'(busy_o), 256'(1'b0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
